// File: rtl/booth_mul_seq_if.sv
// ----------------------------------------------------------------------------
// booth_mul_seq_if
// Request/result bundle between the datapath controller and the sequential
// Booth multiplier.
//
// Handshake: the controller raises start together with the operands; the
// multiplier accepts them on the first rising clk edge where start=1 and
// busy=0. From the cycle after acceptance, busy is high until the product is
// written. done then rises with hi/lo valid, and stays high until the next
// accepted start. start while busy=1 is ignored. Operands are only sampled
// on the accepting edge.
//
// Signals:
//   start         controller -> multiplier  request
//   multiplicand  controller -> multiplier  operand M (WIDTH bits)
//   multiplier    controller -> multiplier  operand Q (WIDTH bits)
//   uns           controller -> multiplier  unsigned select
//                                           (only with BOOTH_MUL_UNSIGNED_EN)
//   busy          multiplier -> controller  multiply in progress
//   done          multiplier -> controller  hi/lo hold a valid product
//   hi, lo        multiplier -> controller  product upper/lower words
// ----------------------------------------------------------------------------
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
`ifdef BOOTH_MUL_UNSIGNED_EN
  logic             uns;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef BOOTH_MUL_UNSIGNED_EN
  modport master (
    output start, multiplicand, multiplier, uns,
    input  busy, done, hi, lo
  );
  modport slave (
    input  start, multiplicand, multiplier, uns,
    output busy, done, hi, lo
  );
`else
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, hi, lo
  );
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, hi, lo
  );
`endif
endinterface

// File: rtl/booth_mul_seq.sv
// ----------------------------------------------------------------------------
// booth_mul_seq
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
// The 2*WIDTH-bit product is returned as hi/lo words for the HI/LO pair.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   bus        booth_mul_seq_if.slave: start/multiplicand/multiplier in,
//              busy/done/hi/lo out (see the interface for the handshake)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature (macro BOOTH_MUL_UNSIGNED_EN): adds bus.uns. With uns=1
// both operands are zero-extended to WIDTH+1 bits and WIDTH+1 steps run;
// hi/lo carry the low 2*WIDTH bits of the unsigned product. Without the
// macro the block is signed only, latency WIDTH.
//
// Latency: start accepted at edge N -> done=1 and hi/lo valid after edge
// N+WIDTH (N+WIDTH+1 for unsigned). busy is high for exactly that many
// cycles. All outputs are registered.
// ----------------------------------------------------------------------------
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           clr,
  booth_mul_seq_if.slave bus,
  output logic [1:0]     dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Unsigned operation needs one extra multiplier bit (the zero sign bit)
  // and one extra Booth step.
`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  logic [1:0]       state;
  logic [WIDTH:0]   acc;     // A, one bit wider than M so -2^(W-1) works
  logic [WIDTH:0]   mcand;   // M, extended to WIDTH+1 bits
  logic [QW-1:0]    q;
  logic             q_1;
  logic [CW-1:0]    count;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
`ifdef BOOTH_MUL_UNSIGNED_EN
  logic             uns_r;
`endif

  // One Booth step: conditional add/subtract, then arithmetic shift right
  // of {A,Q,q_1}.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_n;
  logic [QW-1:0]    q_n;
  logic             q1_n;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_n = {sum[WIDTH], sum[WIDTH:1]};
    q_n   = {sum[0], q[QW-1:1]};
    q1_n  = q[0];
  end

  // Product location after the final step. On the signed path the product
  // is {A, top WIDTH bits of Q}: with the wide Q register the unused sign
  // bit loaded at start has shifted down to Q[0]. On the unsigned path the
  // full {A,Q} is the product, so the low word is Q[WIDTH-1:0] and the high
  // word picks up Q[WIDTH].
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  always_comb begin
    hi_n = acc_n[WIDTH-1:0];
    lo_n = q_n[QW-1 -: WIDTH];
`ifdef BOOTH_MUL_UNSIGNED_EN
    if (uns_r) begin
      hi_n = {acc_n[WIDTH-2:0], q_n[WIDTH]};
      lo_n = q_n[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
      uns_r  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            acc    <= '0;
            q_1    <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
`ifdef BOOTH_MUL_UNSIGNED_EN
            uns_r  <= bus.uns;
            if (bus.uns) begin
              mcand <= {1'b0, bus.multiplicand};
              q     <= {1'b0, bus.multiplier};
              count <= CW'(WIDTH + 1);
            end else begin
              mcand <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
              q     <= {bus.multiplier[WIDTH-1], bus.multiplier};
              count <= CW'(WIDTH);
            end
`else
            mcand  <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            q      <= bus.multiplier;
            count  <= CW'(WIDTH);
`endif
          end
        end
        ST_RUN: begin
          acc   <= acc_n;
          q     <= q_n;
          q_1   <= q1_n;
          count <= count - CW'(1);
          // This edge performs the last step; publish its result directly.
          if (count == CW'(1)) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            hi_r   <= hi_n;
            lo_r   <= lo_n;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign dbg_state = state;

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth signed multiplier; the multiply counterpart of the ALU's sequential non-restoring divider.
- Produces the 2*WIDTH-bit product split into hi/lo words for the HI/LO register pair.
- One Booth step per clock, with a start/busy/done handshake so the datapath controller can stall on it.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- multiplicand  input  WIDTH  operand M, two's complement.
- multiplier  input  WIDTH  operand Q, two's complement.
- busy  output  1  high while a multiply is in progress.
- done  output  1  high when hi/lo hold a valid product; held until the next accepted start.
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset (clr=0, asynchronous): busy=0, done=0, hi=0, lo=0; internal accumulator, Q, q_1 and count all 0; state IDLE. Reset mid-operation aborts the operation and discards any partial result.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at a rising edge (accept):
  - latch M sign-extended to WIDTH+1 bits, Q=multiplier, A=0 (WIDTH+1 bits), q_1=0, count=WIDTH;
  - done<=0, busy<=1; go to RUN.
  - hi/lo keep their previous values until the new result is written.
- RUN, each edge:
  - decode {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged;
  - arithmetic shift right of {A,Q,q_1} by 1 (A MSB replicated);
  - count decrements.
  - On the edge where count reaches 0: go to DONE, busy<=0, done<=1, {hi,lo}<={A[WIDTH-1:0],Q}.
- Latency: start sampled at edge N -> done=1 and result valid after edge N+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy=1 is ignored: no restart, operand inputs not re-sampled.
- Operand inputs are only sampled on the accepting edge; they may change freely afterwards.
- start=1 in DONE begins a new operation on that edge (back-to-back allowed); done drops the following cycle.
- The WIDTH+1-bit accumulator guarantees correct results for M = -2^(WIDTH-1), including (-2^31)*(-2^31) = 2^62.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BOOTH_MUL_UNSIGNED_EN.
- Defined:
  - adds input port uns (1 bit), sampled on the accepting edge.
  - uns=1: both operands zero-extended to WIDTH+1 bits and WIDTH+1 Booth steps run. busy is high WIDTH+1 cycles; done is valid after edge N+WIDTH+1. {hi,lo} is the low 2*WIDTH bits of the unsigned product.
  - uns=0: behaviour identical to the signed path.
- Undefined: port uns absent; signed only; latency WIDTH.

Test Plan:
- Reset, then M=7, Q=-3 (0xFFFFFFFD), start 1 cycle -> busy high 32 cycles; done=1 after edge N+32; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- M=0x80000000, Q=0x80000000 -> hi=0x40000000, lo=0x00000000. Then M=0x7FFFFFFF, Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- M=-1, Q=-1 -> hi=0, lo=1. Then, with done held, start with M=0, Q=0x1234 on the same cycle -> done drops next cycle; after 32 cycles hi=0, lo=0.
- Start M=5, Q=6; at cycle 10 pulse start with M=9, Q=9 -> second start ignored; result hi=0, lo=30 after edge N+32.
- Start M=123, Q=456; assert clr at cycle 15 -> busy, done, hi, lo all 0 immediately. Release clr; start M=2, Q=3 -> lo=6, hi=0.
- With BOOTH_MUL_UNSIGNED_EN: uns=1, M=Q=0xFFFFFFFF -> busy 33 cycles; hi=0xFFFFFFFE, lo=0x00000001. Same operands with uns=0 -> hi=0, lo=1 after 32 cycles.
